// File: rtl/umips_pkg.sv
// umips_pkg: shared hazard-unit FSM encoding and forwarding select constants
package umips_pkg;
    typedef enum logic [1:0] {
        RUN  = 2'd0,
        WAIT = 2'd1,
        ERR  = 2'd2
    } mem_state_t;
    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;
endpackage

// File: rtl/umips_hazard_unit_if.sv
// umips_hazard_unit_if: pipeline-to-hazard-unit signal bundle
interface umips_hazard_unit_if #(parameter int CNT_W = 32);
    logic [4:0] rs_d, rt_d, rs_e, rt_e, write_reg_e, write_reg_m, write_reg_w;
    logic reg_write_e, reg_write_m, reg_write_w, mem_to_reg_e, mem_to_reg_m;
    logic branch_d, mem_req_m, mem_ack, clr_count;
    logic stall_f, stall_d, flush_e, freeze, fwd_a_d, fwd_b_d, bus_err;
    logic [1:0] fwd_a_e, fwd_b_e;
    logic [CNT_W-1:0] stall_count;
    modport master (
        output rs_d, rt_d, rs_e, rt_e, write_reg_e, write_reg_m, write_reg_w,
        output reg_write_e, reg_write_m, reg_write_w, mem_to_reg_e, mem_to_reg_m,
        output branch_d, mem_req_m, mem_ack, clr_count,
        input  stall_f, stall_d, flush_e, freeze, fwd_a_d, fwd_b_d, bus_err,
        input  fwd_a_e, fwd_b_e, stall_count
    );
    modport slave (
        input  rs_d, rt_d, rs_e, rt_e, write_reg_e, write_reg_m, write_reg_w,
        input  reg_write_e, reg_write_m, reg_write_w, mem_to_reg_e, mem_to_reg_m,
        input  branch_d, mem_req_m, mem_ack, clr_count,
        output stall_f, stall_d, flush_e, freeze, fwd_a_d, fwd_b_d, bus_err,
        output fwd_a_e, fwd_b_e, stall_count
    );
endinterface

// File: rtl/umips_fwd_cmp.sv
// umips_fwd_cmp: destination/source register match, r0 never matches
module umips_fwd_cmp (
    input  logic       en,
    input  logic [4:0] dst,
    input  logic [4:0] src,
    output logic       hit
);
    assign hit = en && (dst == src) && (src != 5'd0);
endmodule

// File: rtl/umips_hazard_unit.sv
// umips_hazard_unit: load-use/branch stalls, forwarding selects and memory-wait freeze
module umips_hazard_unit import umips_pkg::*; #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input logic               clk,
    input logic               rst,
    umips_hazard_unit_if.slave h
);
    localparam int WW = $clog2(MEM_TIMEOUT);
    localparam logic [WW-1:0] LAST = WW'(MEM_TIMEOUT - 1);
    logic [11:0] en, hit;
    logic [11:0][4:0] dst, src;
    logic hz, freeze, err;
    mem_state_t state, state_n;
    logic [WW-1:0] wait_cnt, wait_n;
    logic [CNT_W-1:0] cnt;
    // bits 0-3 feed the E-stage ALU muxes, 4-5 the D comparator, 6-7 load-use, 8-11 branch
    assign en  = {h.mem_to_reg_m, h.mem_to_reg_m, h.reg_write_e, h.reg_write_e,
                  h.mem_to_reg_e, h.mem_to_reg_e, h.reg_write_m, h.reg_write_m,
                  h.reg_write_w, h.reg_write_m, h.reg_write_w, h.reg_write_m};
    assign dst = {h.write_reg_m, h.write_reg_m, h.write_reg_e, h.write_reg_e,
                  h.write_reg_e, h.write_reg_e, h.write_reg_m, h.write_reg_m,
                  h.write_reg_w, h.write_reg_m, h.write_reg_w, h.write_reg_m};
    assign src = {h.rt_d, h.rs_d, h.rt_d, h.rs_d, h.rt_d, h.rs_d, h.rt_d, h.rs_d,
                  h.rt_e, h.rt_e, h.rs_e, h.rs_e};
    for (genvar i = 0; i < 12; i++) begin : g_cmp
        umips_fwd_cmp u_cmp (.en(en[i]), .dst(dst[i]), .src(src[i]), .hit(hit[i]));
    end
    assign h.fwd_a_e = hit[0] ? FWD_M : hit[1] ? FWD_W : FWD_RF;
    assign h.fwd_b_e = hit[2] ? FWD_M : hit[3] ? FWD_W : FWD_RF;
    assign h.fwd_a_d = hit[4];
    assign h.fwd_b_d = hit[5];
    assign hz = (|hit[7:6]) || (h.branch_d && (|hit[11:8]));
    always_comb begin
        state_n = state;
        wait_n  = wait_cnt;
        freeze  = 1'b0;
        case (state)
            RUN: if (h.mem_req_m && !h.mem_ack) begin
                state_n = WAIT;
                wait_n  = WW'(1);
                freeze  = 1'b1;
            end
            WAIT: begin
                freeze  = !h.mem_ack;
                state_n = h.mem_ack ? RUN : (wait_cnt == LAST) ? ERR : WAIT;
                wait_n  = (h.mem_ack || wait_cnt == LAST) ? wait_cnt : wait_cnt + WW'(1);
            end
            default: state_n = RUN;
        endcase
    end
    assign err         = state == ERR;
    assign h.freeze    = freeze;
    assign h.bus_err   = err;
    // a timed-out access retires in ERR, so ID/EX takes a bubble instead of holding
    assign h.stall_f   = freeze || (!err && hz);
    assign h.stall_d   = h.stall_f;
    assign h.flush_e   = err || (!freeze && hz);
    assign h.stall_count = cnt;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= RUN;
            wait_cnt <= '0;
            cnt      <= '0;
        end else begin
            state    <= state_n;
            wait_cnt <= wait_n;
            cnt      <= h.clr_count ? '0 : (h.stall_f && !(&cnt)) ? cnt + CNT_W'(1) : cnt;
        end
    end
endmodule
